// File: rtl/first_nios2_system_sysid_checker.sv
// Boot-time system-ID verifier: reads the ID and timestamp words from the sysid slave
// over a read-only Avalon-MM master and reports pass/fail/timeout status to board logic.
module first_nios2_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1380211234,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic        auto_pending_r, auto_pending_s;
    logic [15:0] stall_cnt_r, stall_cnt_s;
    logic        avm_read_r, avm_read_s;
    logic        avm_address_r, avm_address_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        id_ok_r, id_ok_s;
    logic        ts_ok_r, ts_ok_s;
    logic        timeout_r, timeout_s;
    logic [31:0] id_value_r, id_value_s;
    logic [31:0] ts_value_r, ts_value_s;

    // Next-state and next-output logic; bus controls are decoded from the next state
    // so the registered avm_read/avm_address line up with the state they belong to.
    always_comb begin
        state_s        = state_r;
        auto_pending_s = auto_pending_r;
        stall_cnt_s    = stall_cnt_r;
        done_s         = done_r;
        id_ok_s        = id_ok_r;
        ts_ok_s        = ts_ok_r;
        timeout_s      = timeout_r;
        id_value_s     = id_value_r;
        ts_value_s     = ts_value_r;

        case (state_r)
            IDLE: begin
                if (auto_pending_r || start) begin
                    state_s        = RD_ID;
                    auto_pending_s = 1'b0;
                    stall_cnt_s    = 16'd0;
                    done_s         = 1'b0;
                    id_ok_s        = 1'b0;
                    ts_ok_s        = 1'b0;
                    timeout_s      = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_ID: begin
                if (!avm_waitrequest) begin
                    state_s     = RD_TS;
                    stall_cnt_s = 16'd0;
                    id_value_s  = avm_readdata;
                    id_ok_s     = (avm_readdata == EXPECTED_ID);
                end else if (stall_cnt_r == TIMEOUT_LIMIT) begin
                    state_s   = FIN;
                    done_s    = 1'b1;
                    timeout_s = 1'b1;
                    id_ok_s   = 1'b0;
                    ts_ok_s   = 1'b0;
                end else begin
                    stall_cnt_s = stall_cnt_r + 16'd1;
                end
            end
            RD_TS: begin
                if (!avm_waitrequest) begin
                    state_s    = FIN;
                    done_s     = 1'b1;
                    ts_value_s = avm_readdata;
                    ts_ok_s    = (avm_readdata == EXPECTED_TIMESTAMP);
                end else if (stall_cnt_r == TIMEOUT_LIMIT) begin
                    state_s   = FIN;
                    done_s    = 1'b1;
                    timeout_s = 1'b1;
                    id_ok_s   = 1'b0;
                    ts_ok_s   = 1'b0;
                end else begin
                    stall_cnt_s = stall_cnt_r + 16'd1;
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        avm_read_s    = (state_s == RD_ID) || (state_s == RD_TS);
        avm_address_s = (state_s == RD_TS);
        busy_s        = avm_read_s;
    end

    // State and output registers; reset drops the bus request immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            auto_pending_r <= AUTO_START;
            stall_cnt_r    <= 16'd0;
            avm_read_r     <= 1'b0;
            avm_address_r  <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            id_ok_r        <= 1'b0;
            ts_ok_r        <= 1'b0;
            timeout_r      <= 1'b0;
            id_value_r     <= 32'd0;
            ts_value_r     <= 32'd0;
        end else begin
            state_r        <= state_s;
            auto_pending_r <= auto_pending_s;
            stall_cnt_r    <= stall_cnt_s;
            avm_read_r     <= avm_read_s;
            avm_address_r  <= avm_address_s;
            busy_r         <= busy_s;
            done_r         <= done_s;
            id_ok_r        <= id_ok_s;
            ts_ok_r        <= ts_ok_s;
            timeout_r      <= timeout_s;
            id_value_r     <= id_value_s;
            ts_value_r     <= ts_value_s;
        end
    end

    assign avm_read    = avm_read_r;
    assign avm_address = avm_address_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign id_ok       = id_ok_r;
    assign ts_ok       = ts_ok_r;
    assign timeout     = timeout_r;
    assign id_value    = id_value_r;
    assign ts_value    = ts_value_r;

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Scoreboard bench for the sysid checker: a stalling slave model, a result model
// derived from stall counts and data, and a negedge monitor that compares on done.
module tb_first_nios2_system_sysid_checker;

    localparam int          T      = 4;
    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1380211234;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'd0;
    logic        avm_address, avm_read, busy, done, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;

    first_nios2_system_sysid_checker #(
        .EXPECTED_ID(EXP_ID),
        .EXPECTED_TIMESTAMP(EXP_TS),
        .TIMEOUT_CYCLES(T),
        .AUTO_START(1'b1)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .start(start),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata),
        .busy(busy),
        .done(done),
        .id_ok(id_ok),
        .ts_ok(ts_ok),
        .timeout(timeout),
        .id_value(id_value),
        .ts_value(ts_value)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        id_ok;
        logic        ts_ok;
        logic        tmo;
        logic [31:0] idv;
        logic [31:0] tsv;
        int          done_edge;
        int          rd_cycles;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0, n_err = 0, cyc = 0;
    int          rem_id = 0, rem_ts = 0, rd_cnt = 0;
    logic [31:0] id_data = EXP_ID, ts_data = EXP_TS;
    logic [31:0] m_id = 32'd0, m_ts = 32'd0;
    logic        prev_read = 1'b0, prev_wait = 1'b0, prev_addr = 1'b0, prev_done = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: each access takes stall+1 cycles unless the stall exceeds T, in which
    // case it is abandoned after T+1 cycles with both flags cleared.
    task automatic model_push(input logic [31:0] id, input logic [31:0] ts,
                              input int sid, input int sts, input int start_edge);
        exp_t e;
        int a, b;
        e.tmo = 1'b0; e.id_ok = 1'b0; e.ts_ok = 1'b0;
        b = 0;
        if (sid > T) begin
            e.tmo = 1'b1;
            a = T + 1;
        end else begin
            a = sid + 1;
            m_id = id;
            if (sts > T) begin
                e.tmo = 1'b1;
                b = T + 1;
            end else begin
                b = sts + 1;
                m_ts = ts;
                e.id_ok = (id == EXP_ID);
                e.ts_ok = (ts == EXP_TS);
            end
        end
        e.idv = m_id;
        e.tsv = m_ts;
        e.done_edge = start_edge + a + b;
        e.rd_cycles = a + b;
        sb.push_back(e);
    endtask

    // Slave model, protocol checks and scoreboard comparison, all at the falling edge.
    always @(negedge clock) begin : mon
        exp_t e;
        if (!reset_n) begin
            prev_read = 1'b0; prev_wait = 1'b0; prev_addr = 1'b0; prev_done = 1'b0;
            rd_cnt = 0;
            avm_waitrequest = 1'b0;
            avm_readdata = 32'd0;
        end else begin
            if (prev_read && prev_wait && avm_read)
                chk("addr_stable", 32'(avm_address), 32'(prev_addr));
            if (avm_read) begin
                chk("read_busy", 32'(busy), 32'd1);
                rd_cnt++;
            end
            if (done && !prev_done) begin
                if (sb.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_done: got done=1 expected no check pending (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("id_ok", 32'(id_ok), 32'(e.id_ok));
                    chk("ts_ok", 32'(ts_ok), 32'(e.ts_ok));
                    chk("timeout", 32'(timeout), 32'(e.tmo));
                    chk("id_value", id_value, e.idv);
                    chk("ts_value", ts_value, e.tsv);
                    chk("busy_at_done", 32'(busy), 32'd0);
                    chk("done_edge", 32'(cyc), 32'(e.done_edge));
                    chk("read_cycles", 32'(rd_cnt), 32'(e.rd_cycles));
                end
                rd_cnt = 0;
            end
            if (avm_read) begin
                avm_readdata = avm_address ? ts_data : id_data;
                if (avm_address ? (rem_ts > 0) : (rem_id > 0)) begin
                    avm_waitrequest = 1'b1;
                    if (avm_address) rem_ts--; else rem_id--;
                end else begin
                    avm_waitrequest = 1'b0;
                end
            end else begin
                avm_waitrequest = 1'b0;
                avm_readdata = $urandom;
            end
            prev_read = avm_read; prev_wait = avm_waitrequest;
            prev_addr = avm_address; prev_done = done;
        end
    end

    task automatic launch(input logic [31:0] id, input logic [31:0] ts, input int sid, input int sts);
        @(negedge clock);
        id_data = id; ts_data = ts; rem_id = sid; rem_ts = sts;
        model_push(id, ts, sid, sts, cyc + 1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            n_chk++; n_err++;
            $display("FAIL wait_done: got %0d results pending expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clock);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_read", 32'(avm_read), 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clock);
        id_data = EXP_ID; ts_data = EXP_TS; rem_id = 0; rem_ts = 0;
        m_id = 32'd0; m_ts = 32'd0;
        model_push(EXP_ID, EXP_TS, 0, 0, cyc + 1);
        reset_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_read"}, 32'(avm_read), 32'd0);
        chk({tag, "_addr"}, 32'(avm_address), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_id_ok"}, 32'(id_ok), 32'd0);
        chk({tag, "_ts_ok"}, 32'(ts_ok), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
        chk({tag, "_id_value"}, id_value, 32'd0);
        chk({tag, "_ts_value"}, ts_value, 32'd0);
    endtask

    task automatic wait_rd_ts(output bit found);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clock);
            if (avm_read && avm_address) found = 1'b1;
        end
        if (!found) begin
            n_chk++; n_err++;
            $display("FAIL wait_rd_ts: got no timestamp read expected one within 50 cycles");
        end
    endtask

    initial begin
        bit found;
        repeat (3) @(negedge clock);
        #1 check_all_zero("reset");
        release_reset();
        wait_done();

        launch(32'h1, EXP_TS, 0, 0);            wait_done();
        launch(EXP_ID, EXP_TS, 3, 0);           wait_done();
        launch(EXP_ID, EXP_TS, 1000, 0);        wait_done();
        launch(EXP_ID, 32'h5, 0, 1000);         wait_done();

        // start pulse during the timestamp read must be dropped
        launch(EXP_ID, EXP_TS, 0, 3);
        wait_rd_ts(found);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done();
        launch(EXP_ID, EXP_TS, 0, 3);           wait_done();

        // asynchronous reset in the middle of the timestamp read
        launch(EXP_ID, EXP_TS, 0, 3);
        wait_rd_ts(found);
        #1 reset_n = 1'b0;
        sb.delete();
        #1 check_all_zero("midreset");
        repeat (2) @(negedge clock);
        release_reset();
        wait_done();

        for (int k = 0; k < 15; k++) begin
            logic [31:0] rid, rts;
            rid = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom;
            rts = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom;
            launch(rid, rts, $urandom_range(0, 5), $urandom_range(0, 5));
            wait_done();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
